mem_ctrl: RTL and testbench

- Synchronous SRAM-style memory controller: one byte-wide host port, a 64 KiB address space split into NUM_BANKS equal banks.
- Bank is selected by the upper address bits; the remaining bits index the word inside the bank.
- Banks are internal synchronous single-port arrays, one per bank, instantiated or generated inside the block.
- Sits between a simple chip-select/write-enable/output-enable host bus and on-chip storage.

---
 rtl/mem_ctrl.sv | 88 ++++++++
 tb/tb_mem_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide banked synchronous SRAM controller
// Each bank is a single-port array; a registered bank index steers the read mux.

module mem_ctrl_bank #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<IDX_W)-1];

  // rdata only moves on a read of this bank, so it holds between reads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

endmodule

module mem_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int NUM_BANKS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              CE,
  input  logic              CSB,
  input  logic              WEB,
  input  logic              OEB,
  input  logic [DATA_W-1:0] IDATA,
  output logic [DATA_W-1:0] ODATA
);

  localparam int BS_W  = $clog2(NUM_BANKS);
  localparam int IDX_W = ADDR_W - BS_W;

  logic              access;
  logic              wr;
  logic              rd;
  logic [BS_W-1:0]   bank_sel;
  logic [IDX_W-1:0]  idx;
  logic [BS_W-1:0]   rd_bank;
  logic              rd_valid;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

  assign access   = CE & ~CSB & ~RST;
  assign wr       = access & ~WEB;
  assign rd       = access & WEB & ~OEB;
  assign bank_sel = ADDR[ADDR_W-1 -: BS_W];
  assign idx      = ADDR[IDX_W-1:0];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_ctrl_bank #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk   (CLK),
      .en    ((wr | rd) && (bank_sel == BS_W'(b))),
      .we    (~WEB),
      .idx   (idx),
      .wdata (IDATA),
      .rdata (bank_rdata[b])
    );
  end

  // rd_valid masks the un-reset bank registers so ODATA reads 0 after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid <= 1'b0;
    end else if (rd) begin
      rd_valid <= 1'b1;
      rd_bank  <= bank_sel;
    end
  end

  assign ODATA = rd_valid ? bank_rdata[rd_bank] : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomized checks of mem_ctrl against a flat memory model

module tb_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] ADDR;
  logic        CE, CSB, WEB, OEB;
  logic [7:0]  IDATA;
  logic [7:0]  ODATA;

  always #5 CLK = ~CLK;

  mem_ctrl #(.ADDR_W(16), .DATA_W(8), .NUM_BANKS(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .ADDR  (ADDR),
    .CE    (CE),
    .CSB   (CSB),
    .WEB   (WEB),
    .OEB   (OEB),
    .IDATA (IDATA),
    .ODATA (ODATA)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] model [int];
  logic [7:0] exp_q = 8'h00;
  int         waddrs [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic ce, input logic csb, input logic web,
                     input logic oeb, input logic [15:0] a, input logic [7:0] d, input string tag);
    RST = rst; CE = ce; CSB = csb; WEB = web; OEB = oeb; ADDR = a; IDATA = d;
    @(posedge CLK);
    if (rst) exp_q = 8'h00;
    else if (ce && !csb) begin
      if (!web) model[int'(a)] = d;
      else if (!oeb) exp_q = model[int'(a)];
    end
    #1 chk(tag, ODATA, exp_q);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input string tag);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a, d, tag);
    waddrs.push_back(int'(a));
  endtask

  task automatic rd(input logic [15:0] a, input string tag);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00, tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, tag);
  endtask

  initial begin
    // reset, write 0x11, then write attempts under reset
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, "init_rst");
    chk("init_rst_zero", ODATA, 8'h00);
    wr(16'h0000, 8'h11, "pre_rst_wr");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'hFF, "rst_wr_block");
      chk("rst_odata_zero", ODATA, 8'h00);
    end
    rd(16'h0000, "post_rst_rd");
    chk("post_rst_rd_const", ODATA, 8'h11);

    // per-bank write/read
    wr(16'h0000, 8'hA5, "wr_b0"); idle("idle");
    wr(16'h4000, 8'h3C, "wr_b1"); idle("idle");
    wr(16'h8000, 8'h5A, "wr_b2"); idle("idle");
    wr(16'hC000, 8'hC3, "wr_b3"); idle("idle");
    rd(16'h0000, "rd_b0"); chk("rd_b0_const", ODATA, 8'hA5); idle("hold_b0");
    rd(16'h4000, "rd_b1"); chk("rd_b1_const", ODATA, 8'h3C); idle("hold_b1");
    rd(16'h8000, "rd_b2"); chk("rd_b2_const", ODATA, 8'h5A); idle("hold_b2");
    rd(16'hC000, "rd_b3"); chk("rd_b3_const", ODATA, 8'hC3); idle("hold_b3");
    chk("hold_b3_const", ODATA, 8'hC3);

    // bank boundaries
    wr(16'h3FFF, 8'h01, "wr_3fff");
    wr(16'h4000, 8'h02, "wr_4000");
    wr(16'hFFFF, 8'h03, "wr_ffff");
    rd(16'h3FFF, "rd_3fff"); chk("rd_3fff_const", ODATA, 8'h01);
    rd(16'h4000, "rd_4000"); chk("rd_4000_const", ODATA, 8'h02);
    rd(16'hFFFF, "rd_ffff"); chk("rd_ffff_const", ODATA, 8'h03);
    rd(16'h0000, "rd_0000_iso"); chk("rd_0000_iso_const", ODATA, 8'hA5);

    // gating: CE=0 then CSB=1 with a pending write
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h77, "gate_ce");
    chk("gate_ce_hold", ODATA, 8'hA5);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h77, "gate_csb");
    chk("gate_csb_hold", ODATA, 8'hA5);
    rd(16'h0000, "gate_rd"); chk("gate_rd_const", ODATA, 8'hA5);

    // write wins over read when both enables are low
    rd(16'hC000, "prio_pre"); chk("prio_pre_const", ODATA, 8'hC3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 8'h99, "prio_wr");
    chk("prio_hold_const", ODATA, 8'hC3);
    rd(16'h8000, "prio_rd"); chk("prio_rd_const", ODATA, 8'h99);

    // back-to-back reads
    rd(16'h0000, "b2b_0"); chk("b2b_0_const", ODATA, 8'hA5);
    rd(16'h4000, "b2b_1"); chk("b2b_1_const", ODATA, 8'h02);
    rd(16'h8000, "b2b_2"); chk("b2b_2_const", ODATA, 8'h99);

    // randomized traffic; reads only touch written addresses
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [15:0] a;
      logic [7:0]  d;
      op = int'($urandom_range(0, 9));
      a  = 16'($urandom);
      d  = 8'($urandom);
      case (op)
        0, 1, 2: wr(a, d, "rnd_wr");
        3, 4, 5: rd(16'(waddrs[$urandom_range(0, waddrs.size() - 1)]), "rnd_rd");
        6:       cyc(1'b0, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), a, d, "rnd_csb_idle");
        7:       cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), a, d, "rnd_ce_idle");
        8: begin
          cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, d, "rnd_prio");
          waddrs.push_back(int'(a));
        end
        default: begin
          if ($urandom_range(0, 3) == 0)
            cyc(1'b1, 1'b1, 1'b0, 1'($urandom), 1'($urandom), a, d, "rnd_rst");
          else
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, a, d, "rnd_oeb_idle");
        end
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
